// File: rtl/id_ex_stage_pkg.sv
// Shared types for the decode-to-execute stage: word, ALU opcode, register address, slot payload.
package id_ex_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  typedef logic [WORD_W-1:0] word;
  typedef logic [REG_AW-1:0] regaddr_t;

  localparam word ZERO_WORD = WORD_W'(0);

  typedef enum logic [OP_W-1:0] {
    alu_add = 4'd0,
    alu_sub = 4'd1,
    alu_and = 4'd2,
    alu_or  = 4'd3,
    alu_xor = 4'd4,
    alu_sll = 4'd5,
    alu_srl = 4'd6,
    alu_sra = 4'd7
  } aluop;

  typedef struct packed {
    aluop     op;
    word      data1;
    word      data2;
    regaddr_t rs1;
    regaddr_t rs2;
    logic     use_imm;
    regaddr_t rd;
    logic     rd_we;
  } id_ex_payload_t;

  // A writer hits a source only when it writes that register and it is not x0.
  function automatic logic rd_hit(input logic we, input regaddr_t waddr, input regaddr_t rs);
    return we && (waddr == rs) && (rs != REG_AW'(0));
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks MEM, then WB, then register-file data; x0 always reads zero.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic     [REG_AW-1:0] rs,
  input  logic     [WORD_W-1:0] rf_data,
  input  logic                  mem_rd_we,
  input  logic     [REG_AW-1:0] mem_rd_addr,
  input  logic     [WORD_W-1:0] mem_rd_data,
  input  logic                  wb_rd_we,
  input  logic     [REG_AW-1:0] wb_rd_addr,
  input  logic     [WORD_W-1:0] wb_rd_data,
  output logic     [WORD_W-1:0] data_c
);

  always_comb begin
    data_c = rf_data;
    if (rs == REG_AW'(0))
      data_c = ZERO_WORD;
    else if (rd_hit(mem_rd_we, mem_rd_addr, rs))
      data_c = mem_rd_data;
    else if (rd_hit(wb_rd_we, wb_rd_addr, rs))
      data_c = wb_rd_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot feeding the ALU, with operand forwarding, stall snooping and flush.
// Optional: EX_STALL_CNT_EN adds a free-running stall-cycle counter output stall_cnt_o.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  aluop              id_aluop_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [WORD_W-1:0] id_rs1_data_i,
  input  logic [WORD_W-1:0] id_rs2_data_i,
  input  logic [WORD_W-1:0] id_imm_i,
  input  logic              id_use_imm_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rd_we_i,
  input  logic              mem_rd_we_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic [WORD_W-1:0] mem_rd_data_i,
  input  logic              wb_rd_we_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [WORD_W-1:0] wb_rd_data_i,
  input  logic              flush_i,
  input  logic              ALU_busy_i,
  input  logic              ex_ready_i,
  output logic [WORD_W-1:0] ALU_data1_o,
  output logic [WORD_W-1:0] ALU_data2_o,
  output aluop              ALU_op_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_rd_we_o
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam id_ex_payload_t SLOT_RST = '{op: alu_add, data1: ZERO_WORD, data2: ZERO_WORD,
                                         rs1: '0, rs2: '0, use_imm: 1'b0, rd: '0, rd_we: 1'b0};

  id_ex_payload_t slot_q, slot_d;
  logic           valid_q, valid_d;
  logic           advance, capture;
  word            fwd1_c, fwd2_c;

  assign advance    = valid_q & ex_ready_i & ~ALU_busy_i;
  assign id_ready_o = ~valid_q | advance;
  assign capture    = id_valid_i & id_ready_o & ~flush_i;

  id_ex_stage_fwd_mux u_fwd1 (
    .rs(id_rs1_addr_i), .rf_data(id_rs1_data_i),
    .mem_rd_we(mem_rd_we_i), .mem_rd_addr(mem_rd_addr_i), .mem_rd_data(mem_rd_data_i),
    .wb_rd_we(wb_rd_we_i), .wb_rd_addr(wb_rd_addr_i), .wb_rd_data(wb_rd_data_i),
    .data_c(fwd1_c)
  );

  id_ex_stage_fwd_mux u_fwd2 (
    .rs(id_rs2_addr_i), .rf_data(id_rs2_data_i),
    .mem_rd_we(mem_rd_we_i), .mem_rd_addr(mem_rd_addr_i), .mem_rd_data(mem_rd_data_i),
    .wb_rd_we(wb_rd_we_i), .wb_rd_addr(wb_rd_addr_i), .wb_rd_data(wb_rd_data_i),
    .data_c(fwd2_c)
  );

  // Slot next-state: flush > capture > drain > hold (with WB snoop while stalled).
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d        = 1'b1;
      slot_d.op      = id_aluop_i;
      slot_d.data1   = fwd1_c;
      slot_d.data2   = id_use_imm_i ? id_imm_i : fwd2_c;
      slot_d.rs1     = id_rs1_addr_i;
      slot_d.rs2     = id_rs2_addr_i;
      slot_d.use_imm = id_use_imm_i;
      slot_d.rd      = id_rd_addr_i;
      slot_d.rd_we   = id_rd_we_i;
    end else if (advance) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (rd_hit(wb_rd_we_i, wb_rd_addr_i, slot_q.rs1))
        slot_d.data1 = wb_rd_data_i;
      if (!slot_q.use_imm && rd_hit(wb_rd_we_i, wb_rd_addr_i, slot_q.rs2))
        slot_d.data2 = wb_rd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= SLOT_RST;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ALU_data1_o  = slot_q.data1;
  assign ALU_data2_o  = slot_q.data2;
  assign ALU_op_o     = slot_q.op;
  assign ex_rd_addr_o = slot_q.rd;
  assign ex_rd_we_o   = slot_q.rd_we;

`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles where a live instruction could not leave; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= 32'd0;
    else if (flush_i)
      stall_cnt_q <= 32'd0;
    else if (valid_q && !advance)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (optionally built with EX_STALL_CNT_EN).
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid_i;
  logic              id_ready_o;
  aluop              id_aluop_i;
  logic [REG_AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [WORD_W-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic              id_use_imm_i, id_rd_we_i;
  logic              mem_rd_we_i, wb_rd_we_i;
  logic [REG_AW-1:0] mem_rd_addr_i, wb_rd_addr_i;
  logic [WORD_W-1:0] mem_rd_data_i, wb_rd_data_i;
  logic              flush_i, ALU_busy_i, ex_ready_i;
  logic [WORD_W-1:0] ALU_data1_o, ALU_data2_o;
  aluop              ALU_op_o;
  logic              ex_valid_o;
  logic [REG_AW-1:0] ex_rd_addr_o;
  logic              ex_rd_we_o;
`ifdef EX_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_aluop_i(id_aluop_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_use_imm_i(id_use_imm_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i),
    .mem_rd_we_i(mem_rd_we_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_data_i(mem_rd_data_i),
    .wb_rd_we_i(wb_rd_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .flush_i(flush_i), .ALU_busy_i(ALU_busy_i), .ex_ready_i(ex_ready_i),
    .ALU_data1_o(ALU_data1_o), .ALU_data2_o(ALU_data2_o), .ALU_op_o(ALU_op_o),
    .ex_valid_o(ex_valid_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o)
`ifdef EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input aluop op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic use_imm, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rd_we);
    id_valid_i    = 1'b1;
    id_aluop_i    = op;
    id_rs1_addr_i = rs1;
    id_rs1_data_i = d1;
    id_rs2_addr_i = rs2;
    id_rs2_data_i = d2;
    id_use_imm_i  = use_imm;
    id_imm_i      = imm;
    id_rd_addr_i  = rd;
    id_rd_we_i    = rd_we;
  endtask

  task automatic set_mem(input logic we, input logic [4:0] a, input logic [31:0] d);
    mem_rd_we_i = we; mem_rd_addr_i = a; mem_rd_data_i = d;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_rd_we_i = we; wb_rd_addr_i = a; wb_rd_data_i = d;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid_i = 1'b0;
    offer(alu_add, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    id_valid_i = 1'b0;
    set_mem(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    flush_i = 1'b0; ALU_busy_i = 1'b0; ex_ready_i = 1'b1;
    #12;
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_data1", ALU_data1_o, 32'd0);
    check("rst_data2", ALU_data2_o, 32'd0);
    check("rst_op", 32'(ALU_op_o), 32'(alu_add));
    check("rst_rd_we", 32'(ex_rd_we_o), 32'd0);
    check("rst_ready", 32'(id_ready_o), 32'd1);
    rst_n = 1'b1;
    step();

    // Basic pass-through, no hazards.
    offer(alu_add, 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 32'd0, 5'd7, 1'b1);
    step();
    check("basic_data1", ALU_data1_o, 32'h10);
    check("basic_data2", ALU_data2_o, 32'h20);
    check("basic_valid", 32'(ex_valid_o), 32'd1);
    check("basic_rd", 32'(ex_rd_addr_o), 32'd7);
    check("basic_op", 32'(ALU_op_o), 32'(alu_add));

    // MEM beats WB on rs1; rs2 forwarded from WB alone; back-to-back capture.
    offer(alu_and, 5'd5, 32'h1111, 5'd6, 32'h66, 1'b0, 32'd0, 5'd8, 1'b1);
    set_mem(1'b1, 5'd5, 32'hAAAA);
    set_wb(1'b1, 5'd5, 32'hBBBB);
    check("b2b_ready", 32'(id_ready_o), 32'd1);
    step();
    check("fwd_mem_prio", ALU_data1_o, 32'hAAAA);
    check("fwd_no_hit2", ALU_data2_o, 32'h66);
    set_wb(1'b1, 5'd6, 32'hCCCC);
    offer(alu_and, 5'd5, 32'h1111, 5'd6, 32'h66, 1'b0, 32'd0, 5'd8, 1'b1);
    step();
    check("fwd_wb", ALU_data2_o, 32'hCCCC);
    offer(alu_add, 5'd0, 32'h1234, 5'd0, 32'h5678, 1'b0, 32'd0, 5'd8, 1'b1);
    set_mem(1'b1, 5'd0, 32'hAAAA);
    set_wb(1'b1, 5'd0, 32'hBBBB);
    step();
    check("x0_data1", ALU_data1_o, 32'd0);
    check("x0_data2", ALU_data2_o, 32'd0);

    // Immediate wins over a MEM forward on rs2.
    offer(alu_sub, 5'd3, 32'h10, 5'd8, 32'h88, 1'b1, 32'hFFFF_FFF0, 5'd9, 1'b1);
    set_mem(1'b1, 5'd8, 32'h9999);
    set_wb(1'b0, 5'd0, 32'd0);
    step();
    check("imm_data2", ALU_data2_o, 32'hFFFF_FFF0);
    check("imm_op", 32'(ALU_op_o), 32'(alu_sub));
    set_mem(1'b0, 5'd0, 32'd0);

    // ALU busy stall with WB snoop into the held rs2.
    offer(alu_xor, 5'd9, 32'h90, 5'd10, 32'hA0, 1'b0, 32'd0, 5'd11, 1'b1);
    step();
    check("stall_a_data2", ALU_data2_o, 32'hA0);
    offer(alu_or, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'd0, 5'd12, 1'b1);
    ALU_busy_i = 1'b1;
    #1;
    check("stall_ready_c1", 32'(id_ready_o), 32'd0);
    step();
    check("stall_ready_c2", 32'(id_ready_o), 32'd0);
    check("stall_hold_d1", ALU_data1_o, 32'h90);
    set_wb(1'b1, 5'd10, 32'h55);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    check("stall_ready_c3", 32'(id_ready_o), 32'd0);
    check("snoop_data2", ALU_data2_o, 32'h55);
    check("stall_hold_op", 32'(ALU_op_o), 32'(alu_xor));
    check("stall_hold_d1b", ALU_data1_o, 32'h90);
    step();
`ifdef EX_STALL_CNT_EN
    check("stall_cnt3", stall_cnt_o, 32'd3);
`endif
    ALU_busy_i = 1'b0;
    #1;
    check("unstall_ready", 32'(id_ready_o), 32'd1);
    step();
    check("unstall_d1", ALU_data1_o, 32'h1);
    check("unstall_d2", ALU_data2_o, 32'h2);
    check("unstall_op", 32'(ALU_op_o), 32'(alu_or));
    check("unstall_valid", 32'(ex_valid_o), 32'd1);

    // Flush with a held slot and an offered instruction.
    ex_ready_i = 1'b0;
    offer(alu_sll, 5'd13, 32'hDD, 5'd14, 32'hEE, 1'b0, 32'd0, 5'd15, 1'b1);
    flush_i = 1'b1;
    #1;
    check("flush_ready_pre", 32'(id_ready_o), 32'd0);
    step();
    check("flush_valid", 32'(ex_valid_o), 32'd0);
    check("flush_hold_d1", ALU_data1_o, 32'h1);
`ifdef EX_STALL_CNT_EN
    check("flush_cnt", stall_cnt_o, 32'd0);
`endif
    flush_i = 1'b0;
    ex_ready_i = 1'b1;

    // rd = 0 still carries rd_we; then drain with no new instruction.
    offer(alu_srl, 5'd3, 32'h30, 5'd4, 32'h40, 1'b0, 32'd0, 5'd0, 1'b1);
    step();
    check("rd0_we", 32'(ex_rd_we_o), 32'd1);
    check("rd0_addr", 32'(ex_rd_addr_o), 32'd0);
    id_valid_i = 1'b0;
    step();
    check("drain_valid", 32'(ex_valid_o), 32'd0);
    check("drain_hold_d2", ALU_data2_o, 32'h40);

    // Asynchronous reset while stalled.
    ex_ready_i = 1'b0;
    offer(alu_sra, 5'd3, 32'h77, 5'd4, 32'h88, 1'b0, 32'd0, 5'd5, 1'b1);
    step();
    id_valid_i = 1'b0;
    check("pre_rst_valid", 32'(ex_valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ex_valid_o), 32'd0);
    check("async_rst_d1", ALU_data1_o, 32'd0);
    check("async_rst_d2", ALU_data2_o, 32'd0);
    check("async_rst_op", 32'(ALU_op_o), 32'(alu_add));
    step();
    rst_n = 1'b1;
    step();
    check("no_replay", 32'(ex_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage. Sits directly upstream of the ALU.
- Selects operands, applying register/immediate choice and MEM/WB forwarding, then registers them into a one-entry slot that drives the ALU inputs.
- Stalls when the ALU reports busy or the downstream stage is not ready. Supports flush on branch redirect.

Parameters:
- REG_AW, 5, register-address width (32 architectural registers; x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode presents an instruction
- id_ready_o  out  1  stage can accept this cycle
- id_aluop_i  in  aluop  operation
- id_rs1_addr_i / id_rs2_addr_i  in  REG_AW  source registers
- id_rs1_data_i / id_rs2_data_i  in  word  register-file read data
- id_imm_i  in  word  immediate
- id_use_imm_i  in  1  operand 2 = immediate
- id_rd_addr_i  in  REG_AW  destination
- id_rd_we_i  in  1  destination write enable
- mem_rd_we_i, mem_rd_addr_i, mem_rd_data_i  in  1/REG_AW/word  MEM-stage result
- wb_rd_we_i, wb_rd_addr_i, wb_rd_data_i  in  1/REG_AW/word  WB-stage result
- flush_i  in  1  kill held and incoming instruction
- ALU_busy_i  in  1  ALU cannot take a new operation
- ex_ready_i  in  1  downstream (EX/MEM) accepts
- ALU_data1_o / ALU_data2_o  out  word  ALU operands
- ALU_op_o  out  aluop  ALU operation
- ex_valid_o  out  1  slot holds a live instruction
- ex_rd_addr_o  out  REG_AW; ex_rd_we_o  out  1  destination info

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - ex_valid_o = 0, ex_rd_we_o = 0, ex_rd_addr_o = 0.
  - ALU_data1_o = ALU_data2_o = `ZeroWord.
  - ALU_op_o = alu_add.
- Handshake:
  - advance = ex_valid_o & ex_ready_i & ~ALU_busy_i.
  - id_ready_o = ~ex_valid_o | advance. Combinational; no dependence on id_valid_i.
  - capture = id_valid_i & id_ready_o & ~flush_i.
- Slot update, in priority order:
  - flush_i: ex_valid_o <= 0 next cycle. Both the held and the offered instruction are discarded; id_ready_o still reflects the pre-flush state.
  - capture: load all fields; ex_valid_o <= 1. Latency is 1 cycle from ID to ALU inputs.
  - advance without capture: ex_valid_o <= 0. Data fields hold their last value.
  - otherwise: hold.
- Forwarding, operand n:
  - Applies at capture only when rsN != 0.
  - If mem_rd_we_i and mem_rd_addr_i == rsN, take mem_rd_data_i.
  - Else if wb_rd_we_i and wb_rd_addr_i == rsN, take wb_rd_data_i.
  - Else take the register-file data.
  - rsN == 0 always yields `ZeroWord.
  - MEM has priority over WB.
- Operand 2 is id_imm_i when id_use_imm_i; forwarding is not applied to it in that case.
- Stall snooping:
  - While ex_valid_o & ~advance & ~capture, the held slot compares its stored rs1/rs2 (and a stored use_imm flag) against the WB port every cycle.
  - On a match with rs != 0, it overwrites the stored operand with wb_rd_data_i.
  - Prevents stale operands when a producer retires during an ALU-busy stall.
- Simultaneous advance and capture: back-to-back throughput of 1 instruction per cycle.
- Asynchronous reset mid-stall: slot is emptied immediately; no instruction is replayed.
- Instructions with rd == 0 pass through unchanged; ex_rd_we_o is still driven from id_rd_we_i.

Optional Feature:
- EX_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o (32 bits).
  - Counts cycles with ex_valid_o & ~advance.
  - Wraps at 2^32-1 -> 0.
  - Resets to 0; cleared by flush_i.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package (defines.sv): word, aluop, regaddr_t (REG_AW bits), `ZeroWord, plus a struct id_ex_payload_t (op, data1, data2, rs1, rs2, use_imm, rd, rd_we).
- One sub-module: fwd_mux. It is combinational: rs address, rf data, MEM/WB ports -> forwarded word. It is instantiated twice at capture; the snoop logic reuses a WB-only compare.

Test Plan:
- Basic pass: rs1=3 (data 0x10), rs2=4 (0x20), op alu_add, no hazards -> next cycle ALU_data1_o=0x10, ALU_data2_o=0x20, ex_valid_o=1.
- Forward priority: rs1=5, mem writes x5=0xAAAA, wb writes x5=0xBBBB -> ALU_data1_o=0xAAAA. Repeat with rs1=0 -> 0.
- Immediate select: id_use_imm_i=1, imm=0xFFFFFFF0, mem writes rs2 -> ALU_data2_o=0xFFFFFFF0.
- ALU busy stall: hold ALU_busy_i=1 for 3 cycles with the next instruction offered -> id_ready_o=0 for 3 cycles; slot unchanged. A WB write of 0x55 to held rs2 during the stall -> ALU_data2_o=0x55. Busy drops -> advance and capture in the same cycle.
- Flush: flush_i with id_valid_i=1 and a held slot -> ex_valid_o=0 next cycle; stall_cnt_o=0 when EX_STALL_CNT_EN is defined.
- Reset mid-stall: assert rst_n=0 asynchronously while ex_valid_o=1 -> ex_valid_o, ALU_data*_o clear before the next edge; ALU_op_o=alu_add.
